// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_ram_arbiter                                               |
// | Purpose  : Two-port (instruction fetch / load-store) arbiter and         |
// |            sequencer in front of a single SPI RAM controller. One        |
// |            transaction in flight; start pulse, busy tracking, read-data  |
// |            capture and one-cycle acknowledge to the owning port.         |
// | Options  : `define ARB_ROUND_ROBIN_EN -> ties alternate between ports;   |
// |            otherwise the load/store port always wins a tie.              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module spi_ram_arbiter #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_req,
  input  logic [ADDR_BITS-1:0] fetch_addr,
  output logic                 fetch_ack,
  output logic [DATA_BITS-1:0] fetch_data,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic [DATA_BITS-1:0] mem_wdata,
  output logic                 mem_ack,
  output logic [DATA_BITS-1:0] mem_rdata,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_wdata,
  output logic                 ram_start_read,
  output logic                 ram_start_write,
  input  logic [DATA_BITS-1:0] ram_rdata,
  input  logic                 ram_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    ACK    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_owner_mem;       // 1: load/store port owns the transaction
  logic r_is_write;        // direction of the transaction in flight
  logic r_last_grant_mem;  // 1: the most recently completed owner was mem

  logic w_grant;
  logic w_grant_mem;
  logic w_grant_write;
  logic w_done;

  // Arbitration: only evaluated in IDLE while the controller is free
  always_comb begin
    w_grant       = 1'b0;
    w_grant_mem   = 1'b0;
    w_grant_write = 1'b0;
    w_done        = (r_state == WAIT) && !ram_busy;
    if ((r_state == IDLE) && !ram_busy && (fetch_req || mem_req)) begin
      w_grant = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      // On a tie, the port that did not go last wins
      w_grant_mem = mem_req && (!fetch_req || !r_last_grant_mem);
`else
      // Fixed priority: mem wins any tie
      w_grant_mem = mem_req;
`endif
      w_grant_write = w_grant_mem && mem_we;
    end
  end

  // Next-state sequencing
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = ISSUE;
      ISSUE:   w_next = SETTLE;
      SETTLE:  w_next = WAIT;   // busy is ignored while the controller raises it
      WAIT:    if (!ram_busy) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Registered outputs: grant latch, start pulses, read capture and acks
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_mem     <= 1'b0;
      r_is_write      <= 1'b0;
      ram_addr        <= '0;
      ram_wdata       <= '0;
      ram_start_read  <= 1'b0;
      ram_start_write <= 1'b0;
      fetch_ack       <= 1'b0;
      mem_ack         <= 1'b0;
      fetch_data      <= '0;
      mem_rdata       <= '0;
    end else begin
      ram_start_read  <= 1'b0;
      ram_start_write <= 1'b0;
      fetch_ack       <= 1'b0;
      mem_ack         <= 1'b0;
      if (w_grant) begin
        r_owner_mem     <= w_grant_mem;
        r_is_write      <= w_grant_write;
        ram_addr        <= w_grant_mem ? mem_addr : fetch_addr;
        if (w_grant_write) ram_wdata <= mem_wdata;
        ram_start_read  <= !w_grant_write;
        ram_start_write <= w_grant_write;
      end
      if (w_done) begin
        if (!r_is_write) begin
          if (r_owner_mem) mem_rdata  <= ram_rdata;
          else             fetch_data <= ram_rdata;
        end
        fetch_ack <= !r_owner_mem;
        mem_ack   <= r_owner_mem;
      end
    end
  end

  // Remember the owner of each completed transaction for tie-breaking
  always_ff @(posedge clk) begin
    if (rst) r_last_grant_mem <= 1'b0;
    else     r_last_grant_mem <= (r_state == ACK) ? r_owner_mem : r_last_grant_mem;
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spi_ram_arbiter                                            |
// | Purpose  : Self-checking bench for spi_ram_arbiter with a behavioural    |
// |            SPI RAM controller model and an ack scoreboard.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_spi_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_start_read;
  logic        ram_start_write;
  logic [15:0] ram_rdata;
  logic        ram_busy;

  spi_ram_arbiter #(.ADDR_BITS(16), .DATA_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_start_read(ram_start_read), .ram_start_write(ram_start_write),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Controller model: busy for B+1 cycles starting the cycle after a start pulse
  int          bmodel     = 3;
  int          busy_left  = 0;
  logic        force_busy = 1'b0;
  logic [15:0] mem_model [logic [15:0]];

  assign ram_busy = force_busy || (busy_left != 0);

  always @(posedge clk) begin
    if (ram_start_write) mem_model[ram_addr] = ram_wdata;
    if (ram_start_read)
      ram_rdata <= mem_model.exists(ram_addr) ? mem_model[ram_addr] : 16'h0000;
    if (ram_start_read || ram_start_write) busy_left <= bmodel + 1;
    else if (busy_left > 0)                busy_left <= busy_left - 1;
  end

  // Start-pulse monitor
  int          st_cnt = 0;
  int          st_cyc = 0;
  logic [15:0] st_addr;
  logic [15:0] st_wdata;
  logic        st_we;

  always @(negedge clk) begin
    if (ram_start_read || ram_start_write) begin
      check("start_onehot", {31'd0, ram_start_read & ram_start_write}, 32'd0);
      st_cnt++;
      st_cyc   = cyc;
      st_addr  = ram_addr;
      st_wdata = ram_wdata;
      st_we    = ram_start_write;
    end
  end

  // Scoreboard: expected acks in grant order, owner data value after each ack
  typedef struct packed {
    logic        is_mem;
    logic        is_read;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   fetch_ack_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (fetch_ack || mem_ack)) begin
      if (fetch_ack) fetch_ack_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", {31'd0, mem_ack}, {31'd0, e.is_mem});
        check("ack_both", {31'd0, fetch_ack & mem_ack}, 32'd0);
        if (e.is_mem) check("mem_rdata", {16'd0, mem_rdata}, {16'd0, e.data});
        else          check("fetch_data", {16'd0, fetch_data}, {16'd0, e.data});
      end
    end
  end

  task automatic push(input logic is_mem, input logic is_read, input logic [15:0] data);
    exp_t e;
    e.is_mem  = is_mem;
    e.is_read = is_read;
    e.data    = data;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for any ack; returns the cycle and which port acked
  task automatic wait_ack(input string tag, output int at, output logic was_mem);
    at = -1;
    was_mem = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (fetch_ack || mem_ack) begin
        at = cyc;
        was_mem = mem_ack;
        break;
      end
    end
    if (at < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fetch_ack"}, {31'd0, fetch_ack}, 32'd0);
    check({tag, "_mem_ack"},   {31'd0, mem_ack}, 32'd0);
    check({tag, "_starts"},    {30'd0, ram_start_read, ram_start_write}, 32'd0);
    check({tag, "_ram_addr"},  {16'd0, ram_addr}, 32'd0);
    check({tag, "_ram_wdata"}, {16'd0, ram_wdata}, 32'd0);
    check({tag, "_fetch_data"},{16'd0, fetch_data}, 32'd0);
    check({tag, "_mem_rdata"}, {16'd0, mem_rdata}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int   n, at, at2, st0, m, seen, fcnt0;
    logic wm;
    logic [15:0] last_load;

    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    ram_rdata = '0;
    mem_model[16'h0120] = 16'hBEEF;
    last_load = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single fetch, B=3
    bmodel = 3;
    push(1'b0, 1'b1, 16'hBEEF);
    n = cyc; fetch_addr = 16'h0120; fetch_req = 1'b1;
    wait_ack("t1", at, wm);
    fetch_req = 1'b0;
    check("t1_start_cyc", st_cyc, n + 1);
    check("t1_start_addr", {16'd0, st_addr}, 32'h0120);
    check("t1_start_dir", {31'd0, st_we}, 32'd0);
    check("t1_latency", at - n, 7);
    repeat (2) @(negedge clk);

    // Store 1234 to 8000, then load it back
    push(1'b1, 1'b0, last_load);
    mem_we = 1'b1; mem_addr = 16'h8000; mem_wdata = 16'h1234; mem_req = 1'b1;
    wait_ack("t2w", at, wm);
    mem_req = 1'b0;
    check("t2w_dir", {31'd0, st_we}, 32'd1);
    check("t2w_wdata", {16'd0, st_wdata}, 32'h1234);
    check("t2w_addr", {16'd0, st_addr}, 32'h8000);
    @(negedge clk);
    last_load = 16'h1234;
    push(1'b1, 1'b1, last_load);
    mem_we = 1'b0; mem_wdata = 16'hFFFF; mem_req = 1'b1;
    wait_ack("t2r", at, wm);
    mem_req = 1'b0;
    check("t2r_dir", {31'd0, st_we}, 32'd0);
    check("t2r_wdata_hold", {16'd0, ram_wdata}, 32'h1234);

    // Tie with both requests held for 4 transactions, fresh from reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("t3_rst");
    rst = 1'b0;
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    push(1'b1, 1'b1, 16'h1234); push(1'b0, 1'b1, 16'hBEEF);
    push(1'b1, 1'b1, 16'h1234); push(1'b0, 1'b1, 16'hBEEF);
`else
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 16'h1234);
`endif
    fcnt0 = fetch_ack_cnt;
    fetch_addr = 16'h0120; mem_addr = 16'h8000; mem_we = 1'b0;
    fetch_req = 1'b1; mem_req = 1'b1;
    for (int i = 0; i < 4; i++) wait_ack("t3", at, wm);
    fetch_req = 1'b0; mem_req = 1'b0;
    repeat (10) @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    check("t3_fetch_acks", fetch_ack_cnt - fcnt0, 2);
`else
    check("t3_fetch_acks", fetch_ack_cnt - fcnt0, 0);
`endif

    // Controller busy across reset release with a request pending
    force_busy = 1'b1;
    rst = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h8000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    st0 = st_cnt;
    push(1'b1, 1'b1, 16'h1234);
    repeat (6) @(negedge clk);
    check("t4_no_start", st_cnt, st0);
    force_busy = 1'b0;
    m = cyc;
    wait_ack("t4", at, wm);
    mem_req = 1'b0;
    check("t4_start_cyc", st_cyc, m + 1);
    check("t4_start_cnt", st_cnt, st0 + 1);
    repeat (2) @(negedge clk);

    // Reset while waiting on a long busy
    bmodel = 10;
    push(1'b0, 1'b1, 16'hBEEF);
    n = cyc; fetch_addr = 16'h0120; fetch_req = 1'b1;
    while (cyc < n + 5) @(negedge clk);
    rst = 1'b1; fetch_req = 1'b0;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    exp_q.delete();
    st0 = st_cnt;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (fetch_ack || mem_ack) seen++;
    end
    check("t5_no_ack", seen, 0);
    check("t5_no_start", st_cnt, st0);

    // Re-request with B=0: 4-cycle latency, 5-cycle back-to-back spacing
    bmodel = 0;
    push(1'b0, 1'b1, 16'hBEEF);
    push(1'b0, 1'b1, 16'hBEEF);
    n = cyc; fetch_req = 1'b1;
    wait_ack("t6a", at, wm);
    wait_ack("t6b", at2, wm);
    fetch_req = 1'b0;
    check("t6_latency", at - n, 4);
    check("t6_spacing", at2 - at, 5);
    repeat (8) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
